// File: rtl/wdt_pkg.sv
// Shared constants and types for the watchdog register front end.
package wdt_pkg;

  localparam logic [2:0] A_CNT_LO = 3'd0;
  localparam logic [2:0] A_CNT_HI = 3'd1;
  localparam logic [2:0] A_RLD_LO = 3'd2;
  localparam logic [2:0] A_RLD_HI = 3'd3;
  localparam logic [2:0] A_CFG    = 3'd4;
  localparam logic [2:0] A_KEY    = 3'd5;

  localparam logic [7:0] DEF_KEY1 = 8'h55;
  localparam logic [7:0] DEF_KEY2 = 8'hAA;
  localparam logic [7:0] DEF_KICK = 8'hA5;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ARMED    = 2'd1,
    UNLOCKED = 2'd2
  } wdt_lock_t;

  function automatic logic is_protected(input logic [2:0] a);
    return (a == A_CNT_HI) || (a == A_RLD_HI) || (a == A_CFG);
  endfunction

endpackage

// File: rtl/wdt_bus_ctrl_if.sv
// CPU-side 8-bit I/O port into the watchdog register front end.
interface wdt_bus_ctrl_if;
  logic [2:0] addr;
  logic       we;
  logic       re;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output addr, we, re, wdata, input rdata);
  modport slave  (input addr, we, re, wdata, output rdata);
endinterface

// File: rtl/wdt_unlock_fsm.sv
// Two-byte unlock sequencer with window timer; grants one protected write per unlock.
module wdt_unlock_fsm
  import wdt_pkg::*;
#(
  parameter int         UNLOCK_WINDOW = 16,
  parameter logic [7:0] KEY1          = DEF_KEY1,
  parameter logic [7:0] KEY2          = DEF_KEY2,
  parameter logic [7:0] KICK          = DEF_KICK
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_we,
  input  logic [7:0] key_val,
  input  logic       prot_we,
  input  logic       other_we,
  output wdt_lock_t  state,
  output logic       allow,
  output logic       violation
);

  localparam int TW = (UNLOCK_WINDOW > 1) ? $clog2(UNLOCK_WINDOW) : 1;
  localparam logic [TW-1:0] LOAD = TW'(UNLOCK_WINDOW - 1);

  wdt_lock_t     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOCKED;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    allow     = 1'b0;
    violation = 1'b0;
    if (state_q == ARMED) timer_d = timer_q - TW'(1);
    if (key_we) begin
      if (key_val == KICK) begin
        state_d = LOCKED;
      end else begin
        case (state_q)
          LOCKED: if (key_val == KEY1) begin
            state_d = ARMED;
            timer_d = LOAD;
          end
          ARMED:   state_d = (key_val == KEY2) ? UNLOCKED : LOCKED;
          default: state_d = LOCKED;
        endcase
      end
    end else if (prot_we) begin
      // Either the single granted write or a violation; both relock.
      allow     = (state_q == UNLOCKED);
      violation = (state_q != UNLOCKED);
      state_d   = LOCKED;
    end else if (other_we) begin
      if (state_q == ARMED) state_d = LOCKED;
    end else if (state_q == ARMED && timer_q == '0) begin
      state_d = LOCKED;
    end
    if (state_d != ARMED) timer_d = '0;
  end

  assign state = state_q;

endmodule

// File: rtl/wdt_bus_ctrl.sv
// Watchdog register front end: byte decode, atomic reload/counter access, write protection.
module wdt_bus_ctrl
  import wdt_pkg::*;
#(
  parameter int         UNLOCK_WINDOW = 16,
  parameter logic [7:0] KEY1          = DEF_KEY1,
  parameter logic [7:0] KEY2          = DEF_KEY2,
  parameter logic [7:0] KICK          = DEF_KICK
) (
  input  logic           clk,
  input  logic           reset_n,
  wdt_bus_ctrl_if.slave  bus,
  input  logic [15:0]    counter_out,
  input  logic [15:0]    reload_out,
  input  logic [7:0]     config_out,
  output logic [15:0]    counter_in,
  output logic [15:0]    reload_in,
  output logic [7:0]     config_in,
  output logic [1:0]     counter_write,
  output logic [1:0]     reload_write,
  output logic           config_write,
  output logic           zero_write
);

  wdt_lock_t  state;
  logic       allow, violation;
  logic       key_we, prot_we, other_we;
  logic [7:0] rd_mux, rdata_q, staged_lo, shadow_hi;

  assign key_we   = bus.we && (bus.addr == A_KEY);
  assign prot_we  = bus.we && is_protected(bus.addr);
  assign other_we = bus.we && !key_we && !prot_we;

  wdt_unlock_fsm #(
    .UNLOCK_WINDOW (UNLOCK_WINDOW),
    .KEY1          (KEY1),
    .KEY2          (KEY2),
    .KICK          (KICK)
  ) u_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_we    (key_we),
    .key_val   (bus.wdata),
    .prot_we   (prot_we),
    .other_we  (other_we),
    .state     (state),
    .allow     (allow),
    .violation (violation)
  );

  // Reads see pre-write values since everything here is sampled before the edge.
  always_comb begin
    rd_mux = 8'h00;
    case (bus.addr)
      A_CNT_LO: rd_mux = counter_out[7:0];
      A_CNT_HI: rd_mux = shadow_hi;
      A_RLD_LO: rd_mux = reload_out[7:0];
      A_RLD_HI: rd_mux = reload_out[15:8];
      A_CFG:    rd_mux = config_out;
      A_KEY:    rd_mux = {6'b0, state};
      default:  rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q       <= '0;
      staged_lo     <= '0;
      shadow_hi     <= '0;
      counter_in    <= '0;
      reload_in     <= '0;
      config_in     <= '0;
      counter_write <= '0;
      reload_write  <= '0;
      config_write  <= 1'b0;
      zero_write    <= 1'b0;
    end else begin
      counter_write <= '0;
      reload_write  <= '0;
      config_write  <= 1'b0;
      zero_write    <= violation;
      if (bus.re) begin
        rdata_q <= rd_mux;
        if (bus.addr == A_CNT_LO) shadow_hi <= counter_out[15:8];
      end
      if (bus.we) begin
        case (bus.addr)
          A_CNT_LO: begin
            counter_write   <= 2'b01;
            counter_in[7:0] <= bus.wdata;
          end
          A_RLD_LO: staged_lo <= bus.wdata;
          A_CNT_HI: if (allow) begin
            counter_write    <= 2'b10;
            counter_in[15:8] <= bus.wdata;
          end
          A_RLD_HI: if (allow) begin
            reload_write <= 2'b11;
            reload_in    <= {bus.wdata, staged_lo};
          end
          A_CFG: if (allow) begin
            config_write <= 1'b1;
            config_in    <= bus.wdata;
          end
          A_KEY: if (bus.wdata == KICK) begin
            counter_write <= 2'b11;
            counter_in    <= reload_out;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_wdt_bus_ctrl.sv
// Directed test-plan sequences plus randomized traffic against a cycle-level reference model.
module tb_wdt_bus_ctrl;
  import wdt_pkg::*;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] counter_out, reload_out, counter_in, reload_in;
  logic [7:0]  config_out, config_in;
  logic [1:0]  counter_write, reload_write;
  logic        config_write, zero_write;

  wdt_bus_ctrl_if bus();

  wdt_bus_ctrl #(.UNLOCK_WINDOW(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .counter_out   (counter_out),
    .reload_out    (reload_out),
    .config_out    (config_out),
    .counter_in    (counter_in),
    .reload_in     (reload_in),
    .config_in     (config_in),
    .counter_write (counter_write),
    .reload_write  (reload_write),
    .config_write  (config_write),
    .zero_write    (zero_write)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: lock state 0/1/2, cycle stamp of the KEY1 write.
  int          m_st = 0, m_arm = 0, m_cyc = 0;
  logic [7:0]  m_stage = 0, m_shadow = 0, m_rd = 0;
  logic [1:0]  e_cw, e_rw;
  logic        e_cfgw, e_zw;
  logic [15:0] e_cin, e_rin;
  logic [7:0]  e_cfgin;

  task automatic tick(input logic rn, input logic w, input logic r,
                      input logic [2:0] a, input logic [7:0] d);
    int st;
    reset_n = rn; bus.we = w; bus.re = r; bus.addr = a; bus.wdata = d;
    m_cyc++;
    e_cw = 0; e_rw = 0; e_cfgw = 0; e_zw = 0;
    st = m_st;
    if (st == 1 && (m_cyc - m_arm) > W) st = 0;
    if (!rn) begin
      m_st = 0; m_stage = 0; m_shadow = 0; m_rd = 0;
      e_cin = 0; e_rin = 0; e_cfgin = 0;
    end else begin
      if (r) begin
        case (a)
          3'd0: begin m_rd = counter_out[7:0]; m_shadow = counter_out[15:8]; end
          3'd1: m_rd = m_shadow;
          3'd2: m_rd = reload_out[7:0];
          3'd3: m_rd = reload_out[15:8];
          3'd4: m_rd = config_out;
          3'd5: m_rd = 8'(st);
          default: m_rd = 8'h00;
        endcase
      end
      if (w) begin
        if (a == 3'd5) begin
          if (d == 8'hA5) begin
            e_cw = 2'b11; e_cin = reload_out; st = 0;
          end else if (st == 0) begin
            if (d == 8'h55) begin st = 1; m_arm = m_cyc; end
          end else if (st == 1) st = (d == 8'hAA) ? 2 : 0;
          else st = 0;
        end else if (a == 3'd1 || a == 3'd3 || a == 3'd4) begin
          if (st == 2) begin
            if (a == 3'd1) begin e_cw = 2'b10; e_cin[15:8] = d; end
            if (a == 3'd3) begin e_rw = 2'b11; e_rin = {d, m_stage}; end
            if (a == 3'd4) begin e_cfgw = 1; e_cfgin = d; end
          end else e_zw = 1;
          st = 0;
        end else begin
          if (a == 3'd0) begin e_cw = 2'b01; e_cin[7:0] = d; end
          if (a == 3'd2) m_stage = d;
          if (st == 1) st = 0;
        end
      end
      m_st = st;
    end
    @(posedge clk); #1;
    chk("strobes", {counter_write, reload_write, config_write, zero_write},
        {e_cw, e_rw, e_cfgw, e_zw});
    if (e_cw[0]) chk("counter_in_lo", counter_in[7:0], e_cin[7:0]);
    if (e_cw[1]) chk("counter_in_hi", counter_in[15:8], e_cin[15:8]);
    if (e_rw != 0) chk("reload_in", reload_in, e_rin);
    if (e_cfgw) chk("config_in", config_in, e_cfgin);
    chk("rdata", bus.rdata, m_rd);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d); tick(1, 1, 0, a, d); endtask
  task automatic rd(input logic [2:0] a); tick(1, 0, 1, a, 8'h00); endtask
  task automatic idle(); tick(1, 0, 0, 3'd0, 8'h00); endtask
  task automatic unlock(); wr(A_KEY, 8'h55); wr(A_KEY, 8'hAA); endtask

  initial begin
    reset_n = 0; bus.we = 0; bus.re = 0; bus.addr = 0; bus.wdata = 0;
    counter_out = 16'h0; reload_out = 16'h0; config_out = 8'h0;
    tick(0, 0, 0, 3'd0, 8'h00);
    tick(0, 1, 1, A_CFG, 8'hFF);
    chk("rst_counter_in", counter_in, 16'h0);
    chk("rst_reload_in", reload_in, 16'h0);
    chk("rst_config_in", config_in, 8'h0);
    chk("rst_rdata", bus.rdata, 8'h0);

    // Locked CFG write
    wr(A_CFG, 8'h01);
    chk("t1_zw", zero_write, 1'b1);
    chk("t1_cfgw", config_write, 1'b0);
    idle();
    chk("t1_zw_single", zero_write, 1'b0);
    rd(A_KEY);
    chk("t1_key", bus.rdata, 8'h00);

    // Unlock then CFG write, second write violates
    wr(A_KEY, 8'h55); idle(); idle(); wr(A_KEY, 8'hAA);
    wr(A_CFG, 8'h01);
    chk("t2_cfgw", config_write, 1'b1);
    chk("t2_cfgin", config_in, 8'h01);
    rd(A_KEY);
    chk("t2_key", bus.rdata, 8'h00);
    wr(A_CFG, 8'h02);
    chk("t2_zw", zero_write, 1'b1);
    wr(A_CFG, 8'h03);
    chk("t2_zw_b2b", zero_write, 1'b1);

    // Window: 16 cycles accepted, 17 expires
    wr(A_KEY, 8'h55); repeat (15) idle(); wr(A_KEY, 8'hAA);
    rd(A_KEY);
    chk("t3_edge_key", bus.rdata, 8'h02);
    wr(A_KEY, 8'h00);
    chk("t3_relock_zw", zero_write, 1'b0);
    wr(A_KEY, 8'h55); repeat (16) idle(); wr(A_KEY, 8'hAA);
    rd(A_KEY);
    chk("t3_key", bus.rdata, 8'h00);
    wr(A_CFG, 8'h01);
    chk("t3_zw", zero_write, 1'b1);

    // Atomic reload
    unlock();
    wr(A_RLD_LO, 8'h34);
    chk("t4_no_rw", reload_write, 2'b00);
    wr(A_KEY, 8'h00);
    unlock();
    wr(A_RLD_HI, 8'h12);
    chk("t4_rw", reload_write, 2'b11);
    chk("t4_rin", reload_in, 16'h1234);
    idle();
    chk("t4_rw_off", reload_write, 2'b00);

    // Kick and shadow
    reload_out = 16'hFF00;
    wr(A_KEY, 8'hA5);
    chk("t5_cw", counter_write, 2'b11);
    chk("t5_cin", counter_in, 16'hFF00);
    chk("t5_zw", zero_write, 1'b0);
    counter_out = 16'h12FF;
    rd(A_CNT_LO);
    chk("t5_lo", bus.rdata, 8'hFF);
    counter_out = 16'h1300;
    rd(A_CNT_HI);
    chk("t5_hi", bus.rdata, 8'h12);

    // Reset discards the unlock
    unlock();
    tick(0, 0, 0, 3'd0, 8'h00);
    wr(A_RLD_HI, 8'h56);
    chk("t6_zw", zero_write, 1'b1);
    chk("t6_rw", reload_write, 2'b00);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      logic [2:0] a;
      int p;
      counter_out = 16'($urandom);
      reload_out  = 16'($urandom);
      config_out  = 8'($urandom);
      p = $urandom_range(0, 9);
      if (p < 2) begin
        wr(A_KEY, 8'h55);
        repeat ($urandom_range(0, 18)) rd(3'($urandom_range(0, 7)));
        wr(A_KEY, 8'hAA);
      end
      case ($urandom_range(0, 3))
        0: d = 8'h55;
        1: d = 8'hAA;
        2: d = 8'hA5;
        default: d = 8'($urandom);
      endcase
      a = 3'($urandom_range(0, 7));
      tick(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom), a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
